// File: rtl/fact_pkg.sv
// Shared definitions for the factorial bus slave and the master that drives it:
// register offsets, state encodings, opcode bit positions and the N limit.
package fact_pkg;

  localparam int MAX_N    = 20;
  localparam int RESULT_W = 64;
  localparam int CNT_W    = 6;

  localparam logic [3:0] ADDR_OPCODE   = 4'h0;
  localparam logic [3:0] ADDR_STATUS   = 4'h1;
  localparam logic [3:0] ADDR_INTR_EN  = 4'h2;
  localparam logic [3:0] ADDR_OPERAND  = 4'h3;
  localparam logic [3:0] ADDR_RESULT_H = 4'h4;
  localparam logic [3:0] ADDR_RESULT_L = 4'h5;

  localparam int OP_START_BIT = 0;
  localparam int OP_CLEAR_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // STATUS register layout: [1:0] state, bit2 overflow.
  function automatic logic [31:0] status_word(input state_t st, input logic ovf);
    return {29'd0, ovf, st};
  endfunction

endpackage

// File: rtl/fact_mul.sv
// Combinational 64x6 multiplier; the product is truncated to 64 bits.
module fact_mul (
  input  logic [63:0] a,
  input  logic [5:0]  b,
  output logic [63:0] p
);

  assign p = a * {58'd0, b};

endmodule

// File: rtl/factorial_core.sv
// Bus-slave factorial engine: memory-mapped registers, an iterative
// one-multiply-per-cycle N! datapath and a registered level interrupt.
module factorial_core #(
  parameter int DATA_W = 32,
  parameter int MAX_N  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [3:0]        s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              m_interrupt
);

  import fact_pkg::*;

  state_t                state_q, state_d;
  logic [RESULT_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  intr_en_q, intr_en_d;
  logic [DATA_W-1:0]     operand_q, operand_d;
  logic [RESULT_W-1:0]   product;
  logic [CNT_W-1:0]      mul_factor;
  logic [DATA_W-1:0]     rd_data;
  logic                  wr_en, rd_en, opcode_wr, start_req, clear_req;

  assign wr_en     = s_sel & s_wr;
  assign rd_en     = s_sel & ~s_wr;
  assign opcode_wr = wr_en && (s_addr == ADDR_OPCODE);
  assign start_req = opcode_wr & s_din[OP_START_BIT];
  assign clear_req = opcode_wr & s_din[OP_CLEAR_BIT];

  // N=0 and N=1 still take one BUSY cycle, multiplying by 1 rather than by cnt.
  assign mul_factor = (cnt_q < CNT_W'(2)) ? CNT_W'(1) : cnt_q;

  fact_mul u_mul (
    .a (result_q),
    .b (mul_factor),
    .p (product)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (clear_req) begin
      state_d  = ST_IDLE;
      result_d = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            if (operand_q > DATA_W'(MAX_N)) begin
              state_d  = ST_DONE;
              result_d = '0;
              ovf_d    = 1'b1;
            end else begin
              state_d  = ST_BUSY;
              result_d = RESULT_W'(1);
              cnt_d    = operand_q[CNT_W-1:0];
            end
          end
        end
        ST_BUSY: begin
          result_d = product;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(2)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // The operand is frozen while a computation is running; INTR_EN is always writable.
  always_comb begin
    intr_en_d = intr_en_q;
    operand_d = operand_q;
    if (wr_en && (s_addr == ADDR_INTR_EN)) begin
      intr_en_d = s_din[0];
    end
    if (wr_en && (s_addr == ADDR_OPERAND) && (state_q != ST_BUSY)) begin
      operand_d = s_din;
    end
  end

  always_comb begin
    rd_data = '0;
    case (s_addr)
      ADDR_STATUS:   rd_data = DATA_W'(status_word(state_q, ovf_q));
      ADDR_INTR_EN:  rd_data = DATA_W'(intr_en_q);
      ADDR_OPERAND:  rd_data = operand_q;
      ADDR_RESULT_H: rd_data = DATA_W'(result_q[63:32]);
      ADDR_RESULT_L: rd_data = DATA_W'(result_q[31:0]);
      default:       rd_data = '0;
    endcase
  end

  // Interrupt is registered from next-state values so it rises with DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      intr_en_q   <= 1'b0;
      operand_q   <= '0;
      s_dout      <= '0;
      m_interrupt <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      intr_en_q   <= intr_en_d;
      operand_q   <= operand_d;
      m_interrupt <= (state_d == ST_DONE) & intr_en_d;
      if (rd_en) begin
        s_dout <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_factorial_core.sv
// Self-checking bench for factorial_core: bus reads push expected data into a
// scoreboard queue that is popped when the registered read data appears.
module tb_factorial_core;

  logic        clk;
  logic        reset;
  logic        s_sel;
  logic        s_wr;
  logic [3:0]  s_addr;
  logic [31:0] s_din;
  logic [31:0] s_dout;
  logic        m_interrupt;

  int n_compared = 0;
  int n_failed   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam logic [3:0] A_OPCODE = 4'h0, A_STATUS = 4'h1, A_INTR_EN = 4'h2,
                         A_OPERAND = 4'h3, A_RES_H = 4'h4, A_RES_L = 4'h5;

  factorial_core #(.DATA_W(32), .MAX_N(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_sel       (s_sel),
    .s_wr        (s_wr),
    .s_addr      (s_addr),
    .s_din       (s_din),
    .s_dout      (s_dout),
    .m_interrupt (m_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = addr; s_din = data;
    @(negedge clk);
    s_sel = 1'b0; s_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = addr;
    @(negedge clk);
    s_sel = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_output(t, {32'd0, s_dout}, {32'd0, e});
  endtask

  // Start a run with operand n and follow it cycle by cycle to DONE.
  task automatic apply_stimulus(input int n, input bit int_en, input logic [63:0] exp_res);
    int          latency;
    logic [31:0] done_status;
    latency     = (n > 20) ? 1 : 1 + ((n - 1 > 1) ? n - 1 : 1);
    done_status = (n > 20) ? 32'h6 : 32'h2;
    bus_write(A_OPERAND, n);
    bus_write(A_OPCODE, 32'h1);
    check_output($sformatf("irq_t1_n%0d", n), {63'd0, m_interrupt},
                 {63'd0, (latency == 1) ? int_en : 1'b0});
    bus_read(A_STATUS, (latency == 1) ? done_status : 32'h1, $sformatf("status_t1_n%0d", n));
    for (int k = 2; k <= latency; k++) begin
      if (k > 2) @(negedge clk);
      check_output($sformatf("irq_t%0d_n%0d", k, n), {63'd0, m_interrupt},
                   {63'd0, (k == latency) ? int_en : 1'b0});
    end
    bus_read(A_STATUS, done_status, $sformatf("status_done_n%0d", n));
    bus_read(A_RES_H, exp_res[63:32], $sformatf("res_h_n%0d", n));
    bus_read(A_RES_L, exp_res[31:0], $sformatf("res_l_n%0d", n));
  endtask

  task automatic clear_engine(input string tag);
    bus_write(A_OPCODE, 32'h2);
    check_output({tag, "_irq"}, {63'd0, m_interrupt}, 64'd0);
    bus_read(A_STATUS, 32'h0, {tag, "_status"});
    bus_read(A_RES_L, 32'h0, {tag, "_res_l"});
  endtask

  initial begin
    reset = 1'b1; s_sel = 1'b0; s_wr = 1'b0; s_addr = '0; s_din = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_output("rst_irq", {63'd0, m_interrupt}, 64'd0);
    check_output("rst_dout", {32'd0, s_dout}, 64'd0);
    bus_read(A_STATUS, 32'h0, "rst_status");
    bus_read(A_INTR_EN, 32'h0, "rst_intr_en");
    bus_read(A_OPERAND, 32'h0, "rst_operand");
    bus_read(A_RES_H, 32'h0, "rst_res_h");

    // N=5 with interrupts, then DONE-state behaviour.
    bus_write(A_INTR_EN, 32'h1);
    apply_stimulus(5, 1'b1, 64'h78);
    bus_read(A_INTR_EN, 32'h1, "intr_en_rb");
    bus_read(A_OPERAND, 32'h5, "operand_rb");
    bus_read(4'hF, 32'h0, "unmapped_rd");
    bus_write(A_INTR_EN, 32'h0);
    check_output("irq_drop_en0", {63'd0, m_interrupt}, 64'd0);
    bus_write(A_INTR_EN, 32'h1);
    check_output("irq_raise_en1", {63'd0, m_interrupt}, 64'd1);
    bus_write(A_OPCODE, 32'h1);
    bus_read(A_STATUS, 32'h2, "start_in_done");
    bus_read(A_RES_L, 32'h78, "res_after_start_in_done");
    bus_write(A_INTR_EN, 32'h1);
    check_output("dout_held", {32'd0, s_dout}, 64'h78);
    clear_engine("clr5");
    bus_read(A_OPERAND, 32'h5, "operand_kept");

    apply_stimulus(20, 1'b1, 64'h21C3677C_82B40000);
    clear_engine("clr20");
    apply_stimulus(0, 1'b1, 64'h1);
    clear_engine("clr0");
    apply_stimulus(1, 1'b1, 64'h1);
    clear_engine("clr1");

    bus_write(A_INTR_EN, 32'h0);
    apply_stimulus(21, 1'b0, 64'h0);
    clear_engine("clr21");

    // CLEAR during the 3rd BUSY cycle of N=10; operand write during BUSY is dropped.
    bus_write(A_INTR_EN, 32'h1);
    bus_write(A_OPERAND, 32'd10);
    bus_write(A_OPCODE, 32'h1);
    @(negedge clk);
    bus_write(A_OPERAND, 32'd3);
    bus_write(A_OPCODE, 32'h2);
    check_output("abort_irq", {63'd0, m_interrupt}, 64'd0);
    bus_read(A_STATUS, 32'h0, "abort_status");
    bus_read(A_RES_L, 32'h0, "abort_res_l");
    bus_read(A_OPERAND, 32'd10, "busy_operand_wr_ignored");
    apply_stimulus(10, 1'b1, 64'h375F00);

    // Reset mid-computation, then START|CLEAR together in IDLE.
    clear_engine("clr10");
    bus_write(A_OPERAND, 32'd20);
    bus_write(A_OPCODE, 32'h1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("midrst_irq", {63'd0, m_interrupt}, 64'd0);
    check_output("midrst_dout", {32'd0, s_dout}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_STATUS, 32'h0, "midrst_status");
    bus_read(A_OPERAND, 32'h0, "midrst_operand");
    bus_read(A_INTR_EN, 32'h0, "midrst_intr_en");
    bus_read(A_RES_H, 32'h0, "midrst_res_h");
    bus_write(A_OPCODE, 32'h3);
    check_output("startclr_irq", {63'd0, m_interrupt}, 64'd0);
    bus_read(A_STATUS, 32'h0, "startclr_status");
    repeat (3) @(negedge clk);
    bus_read(A_STATUS, 32'h0, "startclr_status_later");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
